// File: rtl/encoder_4x2.sv
// encoder_4x2: registered 4-to-2 priority encoder with valid flag and optional
// multi-hot error reporting, enabled by defining ENCODER_4X2_ERR_CHECK_EN.
module encoder_4x2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] in,
  input  logic       err_clr,
  output logic [1:0] out,
  output logic       valid,
  output logic       err,
  output logic [7:0] err_cnt
);
  logic [1:0] w_idx;
  logic [1:0] r_out;
  logic       r_valid;
  always_comb w_idx = in[3] ? 2'd3 : in[2] ? 2'd2 : in[1] ? 2'd1 : 2'd0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out   <= 2'd0;
      r_valid <= 1'b0;
    end else if (en) begin
      r_out   <= w_idx;
      r_valid <= |in;
    end
  end
  assign out   = r_out;
  assign valid = r_valid;
`ifdef ENCODER_4X2_ERR_CHECK_EN
  logic       w_multi;
  logic       r_err;
  logic [7:0] r_err_cnt;
  // clearing the lowest set bit leaves something only if two or more were set
  always_comb w_multi = (in & (in - 4'd1)) != 4'd0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err     <= 1'b0;
      r_err_cnt <= 8'd0;
    end else begin
      if (en) r_err <= w_multi;
      if (err_clr) r_err_cnt <= 8'd0;
      else if (en && w_multi && r_err_cnt != 8'hff) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end
  assign err     = r_err;
  assign err_cnt = r_err_cnt;
`else
  logic w_unused;
  assign w_unused = err_clr;
  assign err      = 1'b0;
  assign err_cnt  = 8'd0;
`endif
endmodule

// File: tb/tb_encoder_4x2.sv
// tb_encoder_4x2: table-driven and randomized checks of encoder_4x2 against a
// behavioural model; error expectations follow ENCODER_4X2_ERR_CHECK_EN.
module tb_encoder_4x2;
`ifdef ENCODER_4X2_ERR_CHECK_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [3:0] in = 4'd0;
  logic       err_clr = 1'b0;
  logic [1:0] out;
  logic       valid;
  logic       err;
  logic [7:0] err_cnt;
  int checks = 0;
  int errors = 0;
  int m_out, m_valid, m_err, m_cnt;

  encoder_4x2 dut (
    .clk(clk), .rst(rst), .en(en), .in(in), .err_clr(err_clr),
    .out(out), .valid(valid), .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] v_in;
    logic       v_en;
    logic [1:0] e_out;
    logic       e_valid;
    logic       e_multi;
  } vec_t;

  function automatic int top_bit(input logic [3:0] v);
    int r = 0;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_out = 0; m_valid = 0; m_err = 0; m_cnt = 0;
  endtask

  task automatic cycle(input logic [3:0] i, input logic e, input logic c);
    int pop;
    in = i; en = e; err_clr = c;
    @(posedge clk);
    pop = $countones(i);
    if (e) begin
      m_out   = (i == 4'd0) ? 0 : top_bit(i);
      m_valid = (i != 4'd0);
      m_err   = ERR_ON && pop >= 2;
    end
    if (ERR_ON) begin
      if (c) m_cnt = 0;
      else if (e && pop >= 2 && m_cnt < 255) m_cnt = m_cnt + 1;
    end
    #1;
  endtask

  task automatic chk_model(input string nm);
    chk({nm, ".out"}, out, m_out);
    chk({nm, ".valid"}, valid, m_valid);
    chk({nm, ".err"}, err, m_err);
    chk({nm, ".err_cnt"}, err_cnt, m_cnt);
  endtask

  initial begin
    vec_t tbl[12];
    int cnt0;
    tbl[0]  = '{4'b0001, 1'b1, 2'd0, 1'b1, 1'b0};
    tbl[1]  = '{4'b0010, 1'b1, 2'd1, 1'b1, 1'b0};
    tbl[2]  = '{4'b0100, 1'b1, 2'd2, 1'b1, 1'b0};
    tbl[3]  = '{4'b1000, 1'b1, 2'd3, 1'b1, 1'b0};
    tbl[4]  = '{4'b0000, 1'b1, 2'd0, 1'b0, 1'b0};
    tbl[5]  = '{4'b0110, 1'b1, 2'd2, 1'b1, 1'b1};
    tbl[6]  = '{4'b1111, 1'b1, 2'd3, 1'b1, 1'b1};
    tbl[7]  = '{4'b0100, 1'b1, 2'd2, 1'b1, 1'b0};
    tbl[8]  = '{4'b0001, 1'b0, 2'd2, 1'b1, 1'b0};
    tbl[9]  = '{4'b0000, 1'b0, 2'd2, 1'b1, 1'b0};
    tbl[10] = '{4'b0011, 1'b1, 2'd1, 1'b1, 1'b1};
    tbl[11] = '{4'b1010, 1'b0, 2'd1, 1'b1, 1'b1};
    model_reset();
    #3;
    chk_model("reset_init");
    #9 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 12; k++) begin
      cnt0 = m_cnt;
      cycle(tbl[k].v_in, tbl[k].v_en, 1'b0);
      chk($sformatf("tbl%0d.out", k), out, tbl[k].e_out);
      chk($sformatf("tbl%0d.valid", k), valid, tbl[k].e_valid);
      chk($sformatf("tbl%0d.err", k), err, ERR_ON & tbl[k].e_multi);
      chk($sformatf("tbl%0d.err_cnt", k), err_cnt,
          cnt0 + ((ERR_ON && tbl[k].v_en && tbl[k].e_multi) ? 1 : 0));
    end
    for (int k = 0; k < 300; k++) cycle(4'b1111, 1'b1, 1'b0);
    chk("sat.err_cnt", err_cnt, ERR_ON ? 255 : 0);
    chk("sat.out", out, 3);
    cycle(4'b0101, 1'b1, 1'b1);
    chk("clr_prio.err_cnt", err_cnt, 0);
    chk("clr_prio.err", err, ERR_ON ? 1 : 0);
    cycle(4'b1100, 1'b1, 1'b0);
    cycle(4'b1100, 1'b1, 1'b0);
    chk("recount.err_cnt", err_cnt, ERR_ON ? 2 : 0);
    cycle(4'b1100, 1'b0, 1'b1);
    chk("clr_no_en.err_cnt", err_cnt, 0);
    chk("clr_no_en.out", out, 3);
    for (int k = 0; k < 400; k++) begin
      cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));
      chk_model($sformatf("rnd%0d", k));
    end
    cycle(4'b1110, 1'b1, 1'b0);
    chk("pre_rst.valid", valid, 1);
    #2 rst = 1'b1;
    in = 4'b0100;
    #1;
    model_reset();
    chk_model("async_rst");
    @(posedge clk); #1;
    chk_model("held_rst");
    @(negedge clk);
    rst = 1'b0;
    in = 4'b0000;
    #1;
    chk_model("rst_release");
    cycle(4'b0000, 1'b1, 1'b0);
    chk_model("post_rst_zero");
    cycle(4'b0010, 1'b1, 1'b0);
    chk_model("post_rst_cap");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
